// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared definitions for the 5-stage MIPS pipeline hazard logic.
//   FWD_*     : Execute operand-select codes (register file / writeback / memory)
//   hz_state_t: multi-cycle stall FSM states
//   REG_ZERO  : architectural $0, which never creates a dependency
//   reg_match : register dependency test that ignores $0
package pipeline_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} hz_state_t;

    function automatic logic reg_match(input logic [4:0] r, input logic [4:0] x);
        return (r != REG_ZERO) && (r == x);
    endfunction

endpackage

// File: rtl/mc_stall_fsm.sv
// mc_stall_fsm: keeps a multi-cycle op in Execute for MC_CYCLES cycles.
//   CLK, CLRn : clock, asynchronous active-low reset
//   MCStartE  : multi-cycle op present in Execute (ignored while BUSY)
//   mcstall   : hold the front end and Execute this cycle
//   BusyE     : FSM is in BUSY
// The first Execute cycle is spent in IDLE, so the counter is loaded with
// MC_CYCLES-2 and the final BUSY cycle (cnt==0) is the op's last, unstalled one.
module mc_stall_fsm
    import pipeline_pkg::*;
#(
    parameter int MC_CYCLES = 4,
    parameter int CNT_W     = 4
) (
    input  logic CLK,
    input  logic CLRn,
    input  logic MCStartE,
    output logic mcstall,
    output logic BusyE
);

    localparam logic [CNT_W-1:0] CNT_INIT = (MC_CYCLES > 1) ? CNT_W'(MC_CYCLES - 2) : '0;
    localparam logic MULTI = (MC_CYCLES > 1);

    hz_state_t state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    always_ff @(posedge CLK or negedge CLRn) begin
        if (!CLRn) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        mcstall   = 1'b0;
        BusyE     = 1'b0;
        case (state)
            IDLE: begin
                mcstall = MCStartE & MULTI;
                if (mcstall) begin
                    state_nxt = BUSY;
                    cnt_nxt   = CNT_INIT;
                end
            end
            BUSY: begin
                BusyE   = 1'b1;
                mcstall = (cnt != '0);
                if (mcstall) cnt_nxt = cnt - 1'b1;
                else         state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: hazard/stall/forward controller for the 5-stage MIPS pipeline.
//   Inputs : Decode/Execute source regs, per-stage dest regs and write enables,
//            load flags (MtoRFSelE/M), BranchD, PCSrcD, MCStartE.
//   Outputs: StallF/D/E, FlushD/E/M, ForwardAE/BE (2b), ForwardAD/BD, BusyE.
//   Optional (HAZARD_PERF_EN): StallCnt, FlushCnt saturating 32-bit counters.
// All outputs are combinational and forced low while CLRn is asserted.
module hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int MC_CYCLES = 4,
    parameter int CNT_W     = 4
) (
    input  logic       CLK,
    input  logic       CLRn,
    input  logic [4:0] RsD,
    input  logic [4:0] RtD,
    input  logic [4:0] RsE,
    input  logic [4:0] RtE,
    input  logic [4:0] WriteRegE,
    input  logic [4:0] WriteRegM,
    input  logic [4:0] WriteRegW,
    input  logic       RFWEE,
    input  logic       RFWEM,
    input  logic       RFWEW,
    input  logic       MtoRFSelE,
    input  logic       MtoRFSelM,
    input  logic       BranchD,
    input  logic       PCSrcD,
    input  logic       MCStartE,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       FlushD,
    output logic       FlushE,
    output logic       FlushM,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       ForwardAD,
    output logic       ForwardBD,
`ifdef HAZARD_PERF_EN
    output logic [31:0] StallCnt,
    output logic [31:0] FlushCnt,
`endif
    output logic       BusyE
);

    logic lwstall, brstall, mcstall, busy, stall_fd;

    mc_stall_fsm #(.MC_CYCLES(MC_CYCLES), .CNT_W(CNT_W)) u_mc (
        .CLK      (CLK),
        .CLRn     (CLRn),
        .MCStartE (MCStartE),
        .mcstall  (mcstall),
        .BusyE    (busy)
    );

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (RFWEM && reg_match(WriteRegM, rs))      return FWD_MEM;
        else if (RFWEW && reg_match(WriteRegW, rs)) return FWD_WB;
        else                                        return FWD_RF;
    endfunction

    always_comb begin
        lwstall = MtoRFSelE & RFWEE &
                  (reg_match(WriteRegE, RsD) | reg_match(WriteRegE, RtD));
        // Decode compares need final values: an ALU result still in Execute or
        // a load still in Memory cannot be forwarded in time.
        brstall = BranchD &
                  ((RFWEE & (reg_match(WriteRegE, RsD) | reg_match(WriteRegE, RtD))) |
                   (MtoRFSelM & (reg_match(WriteRegM, RsD) | reg_match(WriteRegM, RtD))));
        stall_fd = lwstall | brstall | mcstall;
    end

    assign StallE    = CLRn & mcstall;
    assign FlushM    = CLRn & mcstall;
    assign StallF    = CLRn & stall_fd;
    assign StallD    = CLRn & stall_fd;
    // A held Execute instruction must never be bubbled away.
    assign FlushE    = CLRn & (lwstall | brstall) & ~mcstall;
    assign FlushD    = CLRn & PCSrcD & ~stall_fd;
    assign ForwardAE = CLRn ? fwd_sel(RsE) : FWD_RF;
    assign ForwardBE = CLRn ? fwd_sel(RtE) : FWD_RF;
    assign ForwardAD = CLRn & RFWEM & reg_match(WriteRegM, RsD);
    assign ForwardBD = CLRn & RFWEM & reg_match(WriteRegM, RtD);
    assign BusyE     = CLRn & busy;

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt, flush_cnt;

    always_ff @(posedge CLK or negedge CLRn) begin
        if (!CLRn) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (StallD && stall_cnt != '1)              stall_cnt <= stall_cnt + 32'd1;
            if ((FlushD || FlushE) && flush_cnt != '1)  flush_cnt <= flush_cnt + 32'd1;
        end
    end

    assign StallCnt = stall_cnt;
    assign FlushCnt = flush_cnt;
`endif

endmodule
